peripheral_responder: RTL and testbench

PERIPHERAL_RESPONDER -- requirements
Module: peripheral_responder

---
 rtl/periph_pkg.sv | 15 +
 rtl/periph_fifo.sv | 45 ++++
 rtl/peripheral_responder.sv | 131 +++++++++++++
 tb/tb_peripheral_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Shared codes and response-state encoding for the peripheral responder.
// Used by periph_fifo and peripheral_responder.
package periph_pkg;

  localparam logic [1:0] CODE_RESULT = 2'b00;
  localparam logic [1:0] CODE_ACK    = 2'b01;
  localparam logic [1:0] CODE_NACK   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_NACK = 2'd2
  } resp_state_e;

endpackage

// File: rtl/periph_fifo.sv
// Power-of-two result buffer with extra-MSB pointers.
// Caller guarantees no push when full without pop, no pop when empty.
module periph_fifo
  import periph_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_head  = r_mem[r_rd[AW-1:0]];

endmodule

// File: rtl/peripheral_responder.sv
// Buffers core result words for a host and answers each core strobe.
// Define PERIPH_RESP_ACK_EN to enable the ACK/NACK response channel.
module peripheral_responder
  import periph_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [31:0]           from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [1:0]            host_code,
  output logic [DATA_WIDTH-1:0] host_data,
  output logic                  host_valid,
  input  logic                  host_ready,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  accepted_count,
  output logic [CNT_WIDTH-1:0]  dropped_count
);

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic [DATA_WIDTH+1:0]   w_head;
  logic                    r_ovf;
  logic [CNT_WIDTH-1:0]    r_acc;
  logic [CNT_WIDTH-1:0]    r_drp;

  assign w_pop  = !w_empty && host_ready;
  assign w_push = to_peripheral_valid && (!w_full || w_pop);
  assign w_drop = to_peripheral_valid && w_full && !w_pop;

  periph_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({to_peripheral, to_peripheral_data}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign host_valid = !w_empty;
  assign host_code  = w_head[DATA_WIDTH+1:DATA_WIDTH];
  assign host_data  = w_head[DATA_WIDTH-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
      r_acc <= '0;
      r_drp <= '0;
    end else begin
      if (w_push) r_acc <= r_acc + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      if (w_drop && (r_drp != '1)) r_drp <= r_drp + 1'b1;
    end
  end

  assign overflow       = r_ovf;
  assign accepted_count = r_acc;
  assign dropped_count  = r_drp;

`ifdef PERIPH_RESP_ACK_EN
  resp_state_e           r_state;
  logic [DATA_WIDTH-1:0] r_drop_word;
  logic [31:0]           w_acc32;
  logic [31:0]           w_drop32;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_drop_word <= '0;
    end else begin
      unique case (1'b1)
        w_push:  r_state <= ST_ACK;
        w_drop:  r_state <= ST_NACK;
        default: r_state <= ST_IDLE;
      endcase
      if (w_drop) r_drop_word <= to_peripheral_data;
    end
  end

  if (CNT_WIDTH >= 32) begin : g_acc_trunc
    assign w_acc32 = r_acc[31:0];
  end else begin : g_acc_ext
    assign w_acc32 = {{(32-CNT_WIDTH){1'b0}}, r_acc};
  end

  if (DATA_WIDTH >= 32) begin : g_drop_trunc
    assign w_drop32 = r_drop_word[31:0];
  end else begin : g_drop_ext
    assign w_drop32 = {{(32-DATA_WIDTH){1'b0}}, r_drop_word};
  end

  always_comb begin
    from_peripheral       = CODE_RESULT;
    from_peripheral_data  = '0;
    from_peripheral_valid = 1'b0;
    unique case (r_state)
      ST_ACK: begin
        from_peripheral       = CODE_ACK;
        from_peripheral_data  = w_acc32;
        from_peripheral_valid = 1'b1;
      end
      ST_NACK: begin
        from_peripheral       = CODE_NACK;
        from_peripheral_data  = w_drop32;
        from_peripheral_valid = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign from_peripheral       = '0;
  assign from_peripheral_data  = '0;
  assign from_peripheral_valid = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_responder.sv
// Table-driven bench with a FIFO/counter scoreboard for peripheral_responder.
// Response checks follow PERIPH_RESP_ACK_EN as the DUT build does.
module tb_peripheral_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    to_peripheral;
  logic [DW-1:0] to_peripheral_data;
  logic          to_peripheral_valid;
  logic [1:0]    from_peripheral;
  logic [31:0]   from_peripheral_data;
  logic          from_peripheral_valid;
  logic [1:0]    host_code;
  logic [DW-1:0] host_data;
  logic          host_valid;
  logic          host_ready;
  logic          overflow;
  logic [CW-1:0] accepted_count;
  logic [CW-1:0] dropped_count;

  peripheral_responder #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (CW)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .to_peripheral         (to_peripheral),
    .to_peripheral_data    (to_peripheral_data),
    .to_peripheral_valid   (to_peripheral_valid),
    .from_peripheral       (from_peripheral),
    .from_peripheral_data  (from_peripheral_data),
    .from_peripheral_valid (from_peripheral_valid),
    .host_code             (host_code),
    .host_data             (host_data),
    .host_valid            (host_valid),
    .host_ready            (host_ready),
    .overflow              (overflow),
    .accepted_count        (accepted_count),
    .dropped_count         (dropped_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          v;
    logic [1:0]    code;
    logic [31:0]   data;
    logic          rdy;
  } vec_t;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        vld;
    logic [1:0]  code;
    logic [31:0] data;
  } rsp_t;

  vec_t          tv[$];
  ent_t          mq[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_acc;
  logic [CW-1:0] m_drp;
  logic          m_ovf;
  rsp_t          m_rsp;
  int            fpv_seen;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_acc = '0;
    m_drp = '0;
    m_ovf = 1'b0;
    m_rsp = '{vld: 1'b0, code: 2'b00, data: 32'h0};
  endtask

  task automatic add(input logic v, input logic [1:0] c,
                     input logic [31:0] d, input logic r);
    tv.push_back('{v: v, code: c, data: d, rdy: r});
  endtask

  // One clock cycle: drive, check mid-cycle, update model, check after edge.
  task automatic step(input vec_t t);
    int   occ;
    bit   did_pop;
    rsp_t nx;
    rsp_t ex;
    ent_t e;
    to_peripheral_valid = t.v;
    to_peripheral       = t.code;
    to_peripheral_data  = t.data;
    host_ready          = t.rdy;
    #3;
    occ = mq.size();
    chk("host_valid", 64'(host_valid), 64'(occ > 0));
    if (occ > 0) begin
      chk("host_code", 64'(host_code), 64'(mq[0].code));
      chk("host_data", 64'(host_data), 64'(mq[0].data));
    end
    did_pop = t.rdy && (occ > 0);
    if (did_pop) e = mq.pop_front();
`ifdef PERIPH_RESP_ACK_EN
    ex = m_rsp;
`else
    ex = '{vld: 1'b0, code: 2'b00, data: 32'h0};
`endif
    chk("resp_valid", 64'(from_peripheral_valid), 64'(ex.vld));
    chk("resp_code", 64'(from_peripheral), 64'(ex.code));
    chk("resp_data", 64'(from_peripheral_data), 64'(ex.data));
    if (from_peripheral_valid === 1'b1) fpv_seen++;
    nx = '{vld: 1'b0, code: 2'b00, data: 32'h0};
    if (t.v) begin
      if (occ < DEPTH || did_pop) begin
        mq.push_back('{code: t.code, data: t.data});
        m_acc = m_acc + 1'b1;
        nx = '{vld: 1'b1, code: 2'b01, data: 32'(m_acc)};
      end else begin
        if (m_drp != '1) m_drp = m_drp + 1'b1;
        m_ovf = 1'b1;
        nx = '{vld: 1'b1, code: 2'b11, data: t.data};
      end
    end
    @(posedge clock);
    #1;
    m_rsp = nx;
    chk("accepted_count", 64'(accepted_count), 64'(m_acc));
    chk("dropped_count", 64'(dropped_count), 64'(m_drp));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  initial begin
    fpv_seen            = 0;
    reset               = 1'b0;
    to_peripheral_valid = 1'b0;
    to_peripheral       = 2'b00;
    to_peripheral_data  = '0;
    host_ready          = 1'b0;
    model_clear();
    #1;
    chk("rst_host_valid", 64'(host_valid), 64'd0);
    chk("rst_accepted", 64'(accepted_count), 64'd0);
    chk("rst_dropped", 64'(dropped_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_resp_valid", 64'(from_peripheral_valid), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // single strobe, then one drain cycle
    add(1'b1, 2'b00, 32'h0000_002A, 1'b0);
    add(1'b0, 2'b00, 32'h0, 1'b1);
    // nine back-to-back strobes into a depth-8 buffer
    for (int i = 0; i < 9; i++)
      add(1'b1, 2'(i), 32'h100 + 32'(i), 1'b0);
    // full buffer: strobe coincides with a pop
    add(1'b1, 2'b10, 32'hCAFE_0001, 1'b1);
    for (int i = 0; i < 9; i++)
      add(1'b0, 2'b00, 32'h0, 1'b1);
    // ready toggling 1010 across 20 pushes
    for (int i = 0; i < 20; i++)
      add(1'b1, 2'(i + 1), 32'h2000 + 32'(i), (i % 2) == 0);
    for (int i = 0; i < 12; i++)
      add(1'b0, 2'b00, 32'h0, 1'b1);
    // long stall: drop counter saturates
    for (int i = 0; i < 30; i++)
      add(1'b1, 2'b01, 32'hD000_0000 + 32'(i), 1'b0);
    add(1'b0, 2'b00, 32'h0, 1'b0);

    foreach (tv[i]) step(tv[i]);

    // asynchronous reset with entries buffered
    for (int i = 0; i < 9; i++)
      step('{v: 1'b0, code: 2'b00, data: 32'h0, rdy: 1'b1});
    for (int i = 0; i < 5; i++)
      step('{v: 1'b1, code: 2'b11, data: 32'hE0 + 32'(i), rdy: 1'b0});
    to_peripheral_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_host_valid", 64'(host_valid), 64'd0);
    chk("mid_rst_accepted", 64'(accepted_count), 64'd0);
    chk("mid_rst_dropped", 64'(dropped_count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_resp_valid", 64'(from_peripheral_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_clear();

    step('{v: 1'b1, code: 2'b00, data: 32'h0000_0077, rdy: 1'b0});
    step('{v: 1'b0, code: 2'b00, data: 32'h0, rdy: 1'b1});
    step('{v: 1'b0, code: 2'b00, data: 32'h0, rdy: 1'b0});

`ifndef PERIPH_RESP_ACK_EN
    chk("resp_never_valid", 64'(fpv_seen), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
